edge_stage_scheduler: RTL and testbench
=======================================

Name: edge_stage_scheduler

Overview:
- Sequences the five-stage edge pipeline over one IMG_DIM x IMG_DIM image held in the pixel register file.
- Stage order is median, gaussian, sobel, non-max, hysteresis.
- For each stage it scans the image column-by-column, one K-tall column per cycle, and drives register-file read indices and one-hot sub-module enables.
- It generates write addresses for the tmp/angle files from sub-module readable pulses and requests the border-replicating write-back between stages.

Parameters:
- IMG_DIM, 20, image side length in pixels.
- ADDR_W, 9, register-file index width; must satisfy 2^ADDR_W >= IMG_DIM*IMG_DIM.
- DRAIN_MAX, 8, maximum cycles to wait for late sub-module outputs at the end of a row.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- load_end  in  1  image fully loaded; starts a run when the block is IDLE.
- mod_readable  in  1  current sub-module output valid this cycle.
- op  out  3  current operation: 0 IDLE, 1 MED, 2 GAU, 3 SOB, 4 NMS, 5 HYS.
- mod_en  out  5  one-hot enable; bit op-1 set during PREPARE/SCAN/DRAIN.
- mod_clear  out  1  one-cycle pulse flushing the sub-module window at row start.
- rd_valid  out  1  rd_ind* valid this cycle.
- rd_ind0..rd_ind4  out  ADDR_W each  column read indices, top row to bottom.
- wr_en  out  1  write sub-module output to tmp file; during HYS it is the edge_out strobe.
- ang_wr_en  out  1  wr_en qualified by op==SOB.
- wr_ind  out  ADDR_W  write index (window centre).
- wb_start  out  1  one-cycle write-back request.
- wb_gauss  out  1  border width 2 (op==GAU) during wb_start, else 0.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle end-of-run pulse.
- err  out  1  sticky drain-timeout flag; cleared only by reset or at the next run start.

Behaviour:
- Reset is synchronous: state IDLE, op=0, every output 0, all counters 0.
- A reset asserted mid-run aborts the run the same edge; no further enables or writes follow.
- Window height K=5 when op==GAU, otherwise K=3. half=K/2. Rows per stage R=IMG_DIM-K+1. Outputs per row N=IMG_DIM-K+1.
- States:
  - IDLE: load_end=1 -> SET_OP and clear err. load_end is ignored in every other state.
  - SET_OP (1 cycle): op<=op+1; top row r<=0 -> PREPARE.
  - PREPARE (1 cycle): mod_clear=1; col c<=0; write count w<=0; wr_ind<=(r+half)*IMG_DIM+half; drain timer <=0 -> SCAN.
  - SCAN (exactly IMG_DIM cycles): rd_valid=1; rd_ind_k=(r+k)*IMG_DIM+c for k<K; rd_ind_k=0 for k>=K; c increments each cycle. After c==IMG_DIM-1 -> DRAIN.
  - DRAIN: rd_valid=0. Leave when w==N or timer==DRAIN_MAX (set err in the timeout case). If r<R-1: r<=r+1 -> PREPARE. Else if op==HYS -> DONE. Else -> WRITE_BACK.
  - WRITE_BACK (1 cycle): wb_start=1, wb_gauss=(op==GAU) -> SET_OP.
  - DONE (1 cycle): done=1, op<=0 -> IDLE.
- Write rule: in SCAN or DRAIN, mod_readable=1 and w<N -> wr_en=1 at the current wr_ind; then wr_ind+1 and w+1 next cycle.
  - mod_readable with w==N is ignored, as is mod_readable in any other state.
  - mod_readable on the last SCAN cycle is counted normally.
  - A readable in the DRAIN cycle that completes w==N is written, and the transition happens the same edge.
- Combinational outputs (mod_clear, rd_valid, wr_en, ang_wr_en, wb_*, done) are functions of the registered state only, not of same-cycle inputs, except wr_en/ang_wr_en, which also use mod_readable.
- Address arithmetic is unsigned ADDR_W. The maximum index is IMG_DIM*IMG_DIM-1, so no wrap occurs for legal parameters.

Test Plan:
- Reset, then idle 5 cycles -> every output 0. load_end pulse -> SET_OP, then op=1 and mod_en=5'b00001 in PREPARE; first SCAN cycle rd_ind0/1/2=0/20/40, rd_ind3/4=0.
- MED stage with the model raising mod_readable from SCAN cycle 3 onward -> 18 wr_en per row, first wr_ind=21 and last 38. Row r=17 ends at wr_ind 378. Then wb_start=1 with wb_gauss=0, and op becomes 2.
- GAU stage -> rd_ind0..4 = 0/20/40/60/80 at c=0 and 19/39/59/79/99 at c=19. Sixteen rows of 16 writes, first wr_ind=42. wb_start with wb_gauss=1.
- Model never asserts mod_readable in SOB row 0 -> DRAIN lasts 8 cycles, err=1, scheduler continues to row 1 with wr_ind=41. ang_wr_en mirrors wr_en during SOB.
- Extra readable pulses after w==18 -> no wr_en, wr_ind frozen. Full run through HYS -> no wb_start after HYS, a single done pulse, op=0, busy=0. A new load_end clears err.
- Reset asserted during GAU SCAN -> next cycle IDLE, op=0, rd_valid=0, mod_en=0. Following load_end restarts at op=1.

Source files
------------

// File: rtl/edge_stage_scheduler.sv
// Edge pipeline scheduler: runs median, gaussian, sobel, non-max and
// hysteresis over one IMG_DIM x IMG_DIM image. Each stage scans the image
// one K-tall column per cycle and collects sub-module outputs into the
// tmp/angle files, with a border write-back request between stages.
module edge_stage_scheduler #(
  parameter int unsigned IMG_DIM   = 20,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DRAIN_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_end,
  input  logic              mod_readable,
  output logic [2:0]        op,
  output logic [4:0]        mod_en,
  output logic              mod_clear,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_ind0,
  output logic [ADDR_W-1:0] rd_ind1,
  output logic [ADDR_W-1:0] rd_ind2,
  output logic [ADDR_W-1:0] rd_ind3,
  output logic [ADDR_W-1:0] rd_ind4,
  output logic              wr_en,
  output logic              ang_wr_en,
  output logic [ADDR_W-1:0] wr_ind,
  output logic              wb_start,
  output logic              wb_gauss,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(IMG_DIM + 1);
  localparam int unsigned TMR_W = $clog2(DRAIN_MAX + 1);

  localparam logic [2:0] OP_GAU = 3'd2;
  localparam logic [2:0] OP_SOB = 3'd3;
  localparam logic [2:0] OP_HYS = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_OP,
    S_PREPARE,
    S_SCAN,
    S_DRAIN,
    S_WRITE_BACK,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   row;
  logic [CNT_W-1:0]   col;
  logic [CNT_W-1:0]   wcnt;
  logic [TMR_W-1:0]   timer;

  logic               is_gau;
  logic [CNT_W-1:0]   half;
  logic [2:0]         k_sz;
  logic [CNT_W-1:0]   n_out;
  logic               w_full_next;
  logic               drain_tmo;
  logic [ADDR_W-1:0]  rd_idx [5];

  // Window geometry of the current stage (R == N, so n_out also bounds rows)
  always_comb begin
    is_gau = (op == OP_GAU);
    half   = is_gau ? CNT_W'(2) : CNT_W'(1);
    k_sz   = is_gau ? 3'd5 : 3'd3;
    n_out  = is_gau ? CNT_W'(IMG_DIM - 4) : CNT_W'(IMG_DIM - 2);
  end

  // Write strobe and row-completion conditions
  always_comb begin
    wr_en       = ((state == S_SCAN) || (state == S_DRAIN)) && (wcnt < n_out) && mod_readable;
    ang_wr_en   = wr_en && (op == OP_SOB);
    w_full_next = (wcnt == n_out) || (wr_en && (wcnt == n_out - 1'b1));
    drain_tmo   = (timer == TMR_W'(DRAIN_MAX - 1));
  end

  // Column read indices, top row first; rows beyond the window read 0
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      rd_idx[k] = '0;
      if ((state == S_SCAN) && (3'(k) < k_sz))
        rd_idx[k] = (ADDR_W'(row) + ADDR_W'(k)) * ADDR_W'(IMG_DIM) + ADDR_W'(col);
    end
    rd_ind0 = rd_idx[0];
    rd_ind1 = rd_idx[1];
    rd_ind2 = rd_idx[2];
    rd_ind3 = rd_idx[3];
    rd_ind4 = rd_idx[4];
  end

  // State-decoded strobes and enables
  always_comb begin
    mod_en    = '0;
    if (((state == S_PREPARE) || (state == S_SCAN) || (state == S_DRAIN)) && (op != 3'd0))
      mod_en  = 5'(5'd1 << (op - 3'd1));
    mod_clear = (state == S_PREPARE);
    rd_valid  = (state == S_SCAN);
    wb_start  = (state == S_WRITE_BACK);
    wb_gauss  = (state == S_WRITE_BACK) && is_gau;
    done      = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // Sequencer: stage/row/column counters, write pointer and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op     <= '0;
      row    <= '0;
      col    <= '0;
      wcnt   <= '0;
      timer  <= '0;
      wr_ind <= '0;
      err    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ind <= wr_ind + 1'b1;
        wcnt   <= wcnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (load_end) begin
            err   <= 1'b0;
            state <= S_SET_OP;
          end
        end
        S_SET_OP: begin
          op    <= op + 1'b1;
          row   <= '0;
          state <= S_PREPARE;
        end
        S_PREPARE: begin
          col    <= '0;
          wcnt   <= '0;
          timer  <= '0;
          wr_ind <= (ADDR_W'(row) + ADDR_W'(half)) * ADDR_W'(IMG_DIM) + ADDR_W'(half);
          state  <= S_SCAN;
        end
        S_SCAN: begin
          col <= col + 1'b1;
          if (col == CNT_W'(IMG_DIM - 1))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          timer <= timer + 1'b1;
          if (w_full_next || drain_tmo) begin
            if (!w_full_next)
              err <= 1'b1;
            if (row != n_out - 1'b1) begin
              row   <= row + 1'b1;
              state <= S_PREPARE;
            end else if (op == OP_HYS) begin
              state <= S_DONE;
            end else begin
              state <= S_WRITE_BACK;
            end
          end
        end
        S_WRITE_BACK: begin
          state <= S_SET_OP;
        end
        S_DONE: begin
          op    <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_stage_scheduler.sv
// Directed bench for edge_stage_scheduler: one full five-stage run with a
// per-stage expectation table, then err-clear and mid-run reset sequences.
module tb_edge_stage_scheduler;

  localparam int unsigned ADDR_W = 9;
  localparam int BUDGET = 10000;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_end;
  logic              mod_readable;
  logic [2:0]        op;
  logic [4:0]        mod_en;
  logic              mod_clear;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_ind0, rd_ind1, rd_ind2, rd_ind3, rd_ind4;
  logic              wr_en;
  logic              ang_wr_en;
  logic [ADDR_W-1:0] wr_ind;
  logic              wb_start;
  logic              wb_gauss;
  logic              busy;
  logic              done;
  logic              err;

  edge_stage_scheduler #(.IMG_DIM(20), .ADDR_W(ADDR_W), .DRAIN_MAX(8)) dut (
    .clk(clk), .reset(reset), .load_end(load_end), .mod_readable(mod_readable),
    .op(op), .mod_en(mod_en), .mod_clear(mod_clear), .rd_valid(rd_valid),
    .rd_ind0(rd_ind0), .rd_ind1(rd_ind1), .rd_ind2(rd_ind2), .rd_ind3(rd_ind3),
    .rd_ind4(rd_ind4), .wr_en(wr_en), .ang_wr_en(ang_wr_en), .wr_ind(wr_ind),
    .wb_start(wb_start), .wb_gauss(wb_gauss), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd_start;     // first scan column at which the model raises readable
    int silent_row0;  // model never raises readable in row 0
    int rows;
    int npr;          // writes per non-silent row
    int half;
    int first_row;    // row whose first wr_ind is checked
    int first_wr;
    int last_wr;
    int wb_cnt;
    int wb_g;
  } stage_vec_t;

  stage_vec_t vec [5];

  int n_pass = 0;
  int n_total = 0;

  int row_cnt  [6];
  int wcnt     [6][20];
  int row_first[6][20];
  int last_wr  [6];
  int wb_cnt   [6];
  int wb_g     [6];
  int med_c0   [5];
  int gau_c0   [5];
  int gau_c19  [5];
  int sob0_drain, ang_bad, ang_cnt, stray_wr, done_cnt;
  int err_at_gau_wb, hys_wr19, hys_en19;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drives one full run (load_end pulse already applied) and records activity
  task automatic run_full();
    int  o, r_idx, scan_c, first_prep, saw_done;
    logic rd;
    scan_c = 0; first_prep = 1; saw_done = 0;
    for (int cyc = 0; cyc < BUDGET && !saw_done; cyc++) begin
      step();
      load_end = (cyc == 150);  // stray load_end mid-run must be ignored
      o = int'(op);
      if (cyc == 0) begin
        chk("setop_busy", int'(busy), 1);
        chk("setop_op", o, 0);
      end
      if (mod_clear && o >= 1 && o <= 5) begin
        row_cnt[o]++;
        scan_c = 0;
        if (first_prep) begin
          chk("prep_op", o, 1);
          chk("prep_mod_en", int'(mod_en), 1);
          first_prep = 0;
        end
      end
      r_idx = (o >= 1 && o <= 5) ? row_cnt[o] - 1 : -1;
      rd = 1'b0;
      if (o >= 1 && o <= 5 && r_idx >= 0 && rd_valid)
        rd = (scan_c >= vec[o-1].rd_start) && !(vec[o-1].silent_row0 != 0 && r_idx == 0);
      mod_readable = rd;
      #1;
      if (rd_valid && o == 1 && r_idx == 0 && scan_c == 0)
        med_c0 = '{int'(rd_ind0), int'(rd_ind1), int'(rd_ind2), int'(rd_ind3), int'(rd_ind4)};
      if (rd_valid && o == 2 && r_idx == 0 && scan_c == 0)
        gau_c0 = '{int'(rd_ind0), int'(rd_ind1), int'(rd_ind2), int'(rd_ind3), int'(rd_ind4)};
      if (rd_valid && o == 2 && r_idx == 0 && scan_c == 19)
        gau_c19 = '{int'(rd_ind0), int'(rd_ind1), int'(rd_ind2), int'(rd_ind3), int'(rd_ind4)};
      if (rd_valid && o == 5 && r_idx == 0 && scan_c == 19) begin
        hys_wr19 = int'(wr_ind);
        hys_en19 = int'(wr_en);
      end
      if (wr_en) begin
        if (o >= 1 && o <= 5 && r_idx >= 0 && r_idx < 20) begin
          if (wcnt[o][r_idx] == 0) row_first[o][r_idx] = int'(wr_ind);
          wcnt[o][r_idx]++;
          last_wr[o] = int'(wr_ind);
        end else stray_wr++;
      end
      if (ang_wr_en != (wr_en && o == 3)) ang_bad++;
      if (ang_wr_en) ang_cnt++;
      if (o == 3 && r_idx == 0 && busy && !rd_valid && !mod_clear && mod_en != 5'd0) sob0_drain++;
      if (wb_start && o == 2) err_at_gau_wb = int'(err);
      if (wb_start && o >= 0 && o <= 5) begin
        wb_cnt[o]++;
        wb_g[o] += int'(wb_gauss);
      end
      if (rd_valid) scan_c++;
      if (done) begin
        done_cnt++;
        saw_done = 1;
      end
    end
    mod_readable = 1'b0;
    load_end = 1'b0;
    if (!saw_done) chk("run_timeout", 0, 1);
  endtask

  initial begin
    int bad_rows, exp_cnt, seen;

    //              start silent rows npr half frow first last wb  g
    vec[0] = '{2, 0, 18, 18, 1, 0, 21, 378, 1, 0};  // MED
    vec[1] = '{2, 0, 16, 16, 2, 0, 42, 357, 1, 1};  // GAU
    vec[2] = '{2, 1, 18, 18, 1, 1, 41, 378, 1, 0};  // SOB, row 0 starved
    vec[3] = '{2, 0, 18, 18, 1, 0, 21, 378, 1, 0};  // NMS
    vec[4] = '{0, 0, 18, 18, 1, 0, 21, 378, 0, 0};  // HYS, extra readables

    for (int i = 0; i < 6; i++) begin
      row_cnt[i] = 0; last_wr[i] = -1; wb_cnt[i] = 0; wb_g[i] = 0;
      for (int j = 0; j < 20; j++) begin
        wcnt[i][j] = 0; row_first[i][j] = -1;
      end
    end
    sob0_drain = 0; ang_bad = 0; ang_cnt = 0; stray_wr = 0; done_cnt = 0;
    err_at_gau_wb = -1; hys_wr19 = -1; hys_en19 = -1;
    med_c0 = '{-1, -1, -1, -1, -1};
    gau_c0 = '{-1, -1, -1, -1, -1};
    gau_c19 = '{-1, -1, -1, -1, -1};

    reset = 1'b1; load_end = 1'b0; mod_readable = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_ctrl", int'({op, mod_en, mod_clear, rd_valid, wr_en, ang_wr_en,
                             wb_start, wb_gauss, busy, done, err}), 0);
      chk("idle_idx", int'(rd_ind0 | rd_ind1 | rd_ind2 | rd_ind3 | rd_ind4 | wr_ind), 0);
    end

    // Full run
    load_end = 1'b1;
    run_full();

    for (int s = 0; s < 5; s++) begin
      bad_rows = 0;
      for (int r = 0; r < vec[s].rows; r++) begin
        exp_cnt = (vec[s].silent_row0 != 0 && r == 0) ? 0 : vec[s].npr;
        if (wcnt[s+1][r] != exp_cnt) bad_rows++;
        else if (exp_cnt > 0 &&
                 row_first[s+1][r] != (r + vec[s].half) * 20 + vec[s].half) bad_rows++;
      end
      chk($sformatf("op%0d_rows", s + 1), row_cnt[s+1], vec[s].rows);
      chk($sformatf("op%0d_row_writes", s + 1), bad_rows, 0);
      chk($sformatf("op%0d_first_wr", s + 1), row_first[s+1][vec[s].first_row], vec[s].first_wr);
      chk($sformatf("op%0d_last_wr", s + 1), last_wr[s+1], vec[s].last_wr);
      chk($sformatf("op%0d_wb_start", s + 1), wb_cnt[s+1], vec[s].wb_cnt);
      chk($sformatf("op%0d_wb_gauss", s + 1), wb_g[s+1], vec[s].wb_g);
    end

    chk("med_c0_rd0", med_c0[0], 0);
    chk("med_c0_rd1", med_c0[1], 20);
    chk("med_c0_rd2", med_c0[2], 40);
    chk("med_c0_rd34", med_c0[3] + med_c0[4], 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("gau_c0_rd%0d", k), gau_c0[k], 20 * k);
      chk($sformatf("gau_c19_rd%0d", k), gau_c19[k], 20 * k + 19);
    end
    chk("sob0_drain_len", sob0_drain, 8);
    chk("err_before_sob", err_at_gau_wb, 0);
    chk("ang_mirror", ang_bad, 0);
    chk("ang_count", ang_cnt, 17 * 18);
    chk("stray_wr", stray_wr, 0);
    chk("hys_extra_wr_en", hys_en19, 0);
    chk("hys_wr_frozen", hys_wr19, 39);
    chk("wb_idle", wb_cnt[0], 0);
    chk("done_pulse", done_cnt, 1);

    step();
    chk("end_op", int'(op), 0);
    chk("end_busy", int'(busy), 0);
    chk("end_done", int'(done), 0);
    chk("end_err_sticky", int'(err), 1);

    // New load_end clears err, then reset aborts during GAU scan
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    chk("restart_err_clear", int'(err), 0);
    chk("restart_busy", int'(busy), 1);
    seen = 0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      step();
      if (op == 3'd2 && rd_valid) seen = 1;
    end
    chk("reach_gau_scan", seen, 1);
    reset = 1'b1;
    step();
    chk("abort_op", int'(op), 0);
    chk("abort_rd_valid", int'(rd_valid), 0);
    chk("abort_mod_en", int'(mod_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    reset = 1'b0;
    mod_readable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_abort_quiet", int'({busy, wr_en, mod_en, rd_valid}), 0);
    end
    mod_readable = 1'b0;
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    chk("rerun_setop_op", int'(op), 0);
    step();
    chk("rerun_op", int'(op), 1);
    chk("rerun_clear", int'(mod_clear), 1);
    chk("rerun_mod_en", int'(mod_en), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
